// File: rtl/datain_capture_fifo_if.sv
// datain_capture_fifo_if: flit capture, read-out and status signals of the ejection-port capture buffer.
interface datain_capture_fifo_if #(
  parameter int FLIT_W = 20,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(DEPTH);
  logic                    in_valid;
  logic                    in_ready;
  logic [FLIT_W-1:0]       datain;
  logic [FLIT_W-TAG_W-1:0] read;
  logic                    rd_en;
  logic [FLIT_W-1:0]       rd_data;
  logic                    rd_valid;
  logic [AW:0]             count;
  logic                    empty;
  logic                    state;
  logic                    overflow;
  logic [CNT_W-1:0]        rx_cnt;
  modport slave (
    input  in_valid, datain, rd_en,
    output in_ready, read, rd_data, rd_valid, count, empty, state, overflow, rx_cnt
  );
  modport master (
    output in_valid, datain, rd_en,
    input  in_ready, read, rd_data, rd_valid, count, empty, state, overflow, rx_cnt
  );
endinterface

// File: rtl/datain_capture_fifo.sv
// datain_capture_fifo: circular flit store at a NoC ejection port, ring-overwrite or backpressured FIFO.
module datain_capture_fifo #(
  parameter int FLIT_W    = 20,
  parameter int TAG_W     = 4,
  parameter int DEPTH     = 64,
  parameter int WRAP_MODE = 1,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  datain_capture_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              rd_valid_q, rd_valid_d, overflow_q, overflow_d;
  logic [FLIT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic              full, wr, rd, drop;
  // wr_ptr == rd_ptr when full, so a drop advances both pointers together
  always_comb begin
    full       = count_q == (AW+1)'(DEPTH);
    wr         = bus.in_valid && bus.in_ready;
    rd         = bus.rd_en && count_q != '0;
    drop       = wr && !rd && full;
    wr_ptr_d   = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = (rd || drop) ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = (wr && !rd && !full) ? count_q + 1'b1 : (rd && !wr) ? count_q - 1'b1 : count_q;
    rd_valid_d = rd;
    rd_data_d  = rd ? mem[rd_ptr_q] : rd_data_q;
    overflow_d = overflow_q || drop || (WRAP_MODE == 0 && bus.in_valid && full);
    rx_cnt_d   = (wr && !(&rx_cnt_q)) ? rx_cnt_q + 1'b1 : rx_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
      rx_cnt_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr) mem[wr_ptr_q] <= bus.datain;
  end
  assign bus.in_ready = (WRAP_MODE != 0) ? !rst : !full;
  assign bus.read     = bus.datain[FLIT_W-1:TAG_W];
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = count_q == '0;
  assign bus.state    = full;
  assign bus.overflow = overflow_q;
  assign bus.rx_cnt   = rx_cnt_q;
endmodule

// File: tb/tb_datain_capture_fifo.sv
// tb_datain_capture_fifo: two DEPTH=4 instances (backpressure and ring) checked against a queue model.
module tb_datain_capture_fifo;
  localparam int FW = 20, TW = 4, D = 4, CW = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]    rst;
  logic          iv [2];
  logic [FW-1:0] id [2];
  logic          ire [2];
  datain_capture_fifo_if #(.FLIT_W(FW), .TAG_W(TW), .DEPTH(D), .CNT_W(CW)) b0 ();
  datain_capture_fifo_if #(.FLIT_W(FW), .TAG_W(TW), .DEPTH(D), .CNT_W(CW)) b1 ();
  assign b0.in_valid = iv[0];
  assign b0.datain   = id[0];
  assign b0.rd_en    = ire[0];
  assign b1.in_valid = iv[1];
  assign b1.datain   = id[1];
  assign b1.rd_en    = ire[1];
  datain_capture_fifo #(.FLIT_W(FW), .TAG_W(TW), .DEPTH(D), .WRAP_MODE(0), .CNT_W(CW))
    u0 (.clk(clk), .rst(rst[0]), .bus(b0.slave));
  datain_capture_fifo #(.FLIT_W(FW), .TAG_W(TW), .DEPTH(D), .WRAP_MODE(1), .CNT_W(CW))
    u1 (.clk(clk), .rst(rst[1]), .bus(b1.slave));
  int tests = 0, fails = 0;
  logic [FW-1:0] q0 [$];
  logic [FW-1:0] q1 [$];
  logic          mrv [2];
  logic [FW-1:0] mrd [2];
  logic          movf [2];
  int            mrx [2];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Instance k=1 is the ring; k=0 backpressures. Queue front is the oldest flit.
  task automatic model(input int k, input logic r, input logic v, input logic [FW-1:0] d, input logic re);
    logic [FW-1:0] q [$];
    bit rd, wr;
    q = k ? q1 : q0;
    if (r) begin
      q.delete();
      mrv[k] = 0; mrd[k] = '0; movf[k] = 0; mrx[k] = 0;
    end else begin
      rd = re && q.size() > 0;
      wr = v && (k == 1 || q.size() < D);
      if (k == 0 && v && q.size() == D) movf[k] = 1;
      mrv[k] = rd;
      if (rd) mrd[k] = q.pop_front();
      if (wr) begin
        if (q.size() == D) begin
          void'(q.pop_front());
          movf[k] = 1;
        end
        q.push_back(d);
        if (mrx[k] < (1 << CW) - 1) mrx[k]++;
      end
    end
    if (k) q1 = q; else q0 = q;
  endtask
  task automatic post(input int j);
    logic rv, e, s, o;
    logic [FW-1:0] rdd;
    logic [TW-1:0] c;
    logic [CW-1:0] rx;
    int n;
    n = j ? q1.size() : q0.size();
    if (j) begin
      rv = b1.rd_valid; e = b1.empty; s = b1.state; o = b1.overflow; rdd = b1.rd_data; c = TW'(b1.count); rx = b1.rx_cnt;
    end else begin
      rv = b0.rd_valid; e = b0.empty; s = b0.state; o = b0.overflow; rdd = b0.rd_data; c = TW'(b0.count); rx = b0.rx_cnt;
    end
    check($sformatf("rd_valid%0d", j), 32'(rv), 32'(mrv[j]));
    check($sformatf("rd_data%0d", j), 32'(rdd), 32'(mrd[j]));
    check($sformatf("count%0d", j), 32'(c), 32'(n));
    check($sformatf("empty%0d", j), 32'(e), 32'(n == 0));
    check($sformatf("state%0d", j), 32'(s), 32'(n == D));
    check($sformatf("overflow%0d", j), 32'(o), 32'(movf[j]));
    check($sformatf("rx_cnt%0d", j), 32'(rx), 32'(mrx[j]));
  endtask
  task automatic step(input int k, input logic [1:0] rm, input logic v, input logic [FW-1:0] d, input logic re);
    rst = rm;
    iv[0] = 0; iv[1] = 0; ire[0] = 0; ire[1] = 0; id[0] = '0; id[1] = '0;
    iv[k] = v; id[k] = d; ire[k] = re;
    #1;
    check("read0", 32'(b0.read), 32'(id[0][FW-1:TW]));
    check("read1", 32'(b1.read), 32'(id[1][FW-1:TW]));
    if (!rst[0]) check("in_ready0", 32'(b0.in_ready), 32'(q0.size() < D));
    check("in_ready1", 32'(b1.in_ready), 32'(!rst[1]));
    @(posedge clk);
    for (int j = 0; j < 2; j++) model(j, rst[j], iv[j], id[j], ire[j]);
    #1;
    post(0);
    post(1);
  endtask
  initial begin
    rst = '1;
    iv[0] = 0; iv[1] = 0; ire[0] = 0; ire[1] = 0; id[0] = '0; id[1] = '0;
    step(0, 2'b11, 0, '0, 0);
    for (int i = 1; i <= 4; i++) step(0, 2'b00, 1, FW'(32'h11 * i), 0);
    check("bp_count", 32'(b0.count), 4);
    check("bp_state", 32'(b0.state), 1);
    check("bp_in_ready", 32'(b0.in_ready), 0);
    check("bp_rx", 32'(b0.rx_cnt), 4);
    step(0, 2'b00, 1, 20'h00055, 0);
    check("bp_ovf", 32'(b0.overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 2'b00, 0, '0, 1);
      check("bp_pop", 32'(b0.rd_data), 32'h11 * i);
    end
    check("bp_empty", 32'(b0.empty), 1);
    step(1, 2'b10, 0, '0, 0);
    for (int i = 1; i <= 6; i++) step(1, 2'b00, 1, FW'(32'h10 * i), 0);
    check("ring_count", 32'(b1.count), 4);
    check("ring_ovf", 32'(b1.overflow), 1);
    check("ring_rx", 32'(b1.rx_cnt), 6);
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b00, 0, '0, 1);
      check("ring_pop", 32'(b1.rd_data), 32'h30 + 32'h10 * i);
    end
    step(1, 2'b10, 0, '0, 0);
    for (int i = 1; i <= 4; i++) step(1, 2'b00, 1, FW'(i), 0);
    step(1, 2'b00, 1, 20'h000A0, 1);
    check("ring_rw_data", 32'(b1.rd_data), 1);
    check("ring_rw_count", 32'(b1.count), 4);
    check("ring_rw_ovf", 32'(b1.overflow), 0);
    step(1, 2'b10, 0, '0, 0);
    step(1, 2'b00, 1, 20'hABCD5, 1);
    check("byp_rv", 32'(b1.rd_valid), 0);
    check("byp_count", 32'(b1.count), 1);
    step(1, 2'b00, 0, '0, 1);
    check("byp_pop", 32'(b1.rd_data), 32'hABCD5);
    step(1, 2'b00, 0, 20'hABCD5, 0);
    check("live_read", 32'(b1.read), 32'hABCD);
    step(1, 2'b00, 0, '0, 1);
    check("empty_rd", 32'(b1.rd_valid), 0);
    for (int i = 1; i <= 3; i++) step(1, 2'b00, 1, FW'(32'h100 * i), 0);
    step(1, 2'b10, 1, 20'h00777, 0);
    check("rst_count", 32'(b1.count), 0);
    check("rst_empty", 32'(b1.empty), 1);
    check("rst_rx", 32'(b1.rx_cnt), 0);
    step(1, 2'b00, 0, '0, 1);
    check("rst_nostore", 32'(b1.rd_valid), 0);
    step(0, 2'b01, 0, '0, 0);
    for (int i = 0; i < 9; i++) step(0, 2'b00, 1, FW'(i + 1), i > 0);
    check("rx_sat", 32'(b0.rx_cnt), 7);
    for (int i = 0; i < 3000; i++)
      step(int'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0) ? 2'b11 : 2'b00,
           $urandom_range(0, 9) < 6, FW'($urandom), $urandom_range(0, 9) < 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
